vx_raster_stamp_packer: RTL



---
 rtl/vx_raster_stamp_packer_pkg.sv | 22 ++
 rtl/vx_raster_pack_buf.sv | 52 +++++
 rtl/vx_raster_stamp_packer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vx_raster_stamp_packer_pkg.sv
// rtl/vx_raster_stamp_packer_pkg.sv - shared raster stamp types, widths and packer FSM states
package vx_raster_stamp_packer_pkg;

    typedef struct packed {
        logic [63:0] bcoords;
        logic [15:0] pid;
        logic [15:0] mask;
        logic [15:0] pos_y;
        logic [15:0] pos_x;
    } stamp_t;

    localparam int STAMP_W      = $bits(stamp_t);
    localparam int RASTER_LANES = 4;

    typedef logic [RASTER_LANES-1:0] lane_mask_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } pack_state_t;

endpackage

// File: rtl/vx_raster_pack_buf.sv
// rtl/vx_raster_pack_buf.sv - stamp fill buffer with occupancy count and zero-padded lane view
module vx_raster_pack_buf #(
    parameter int NUM_LANES = 4,
    parameter int STAMP_W   = 128,
    parameter int CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [STAMP_W-1:0]           push_data,
    input  logic                         pop,
    output logic [CNT_W-1:0]             count,
    output logic [NUM_LANES*STAMP_W-1:0] lanes,
    output logic [NUM_LANES-1:0]         lane_mask
);

    logic [STAMP_W-1:0] slot [NUM_LANES];
    logic [CNT_W-1:0]   wr_idx;

    // A push that coincides with a pop lands in slot 0 of the emptied buffer.
    assign wr_idx = pop ? '0 : count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (pop) begin
            count <= push ? CNT_W'(1) : '0;
        end else if (push) begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (push && (wr_idx == CNT_W'(i))) begin
                slot[i] <= push_data;
            end
        end
    end

    always_comb begin
        lanes     = '0;
        lane_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (CNT_W'(i) < count) begin
                lanes[i*STAMP_W +: STAMP_W] = slot[i];
                lane_mask[i]                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_raster_stamp_packer.sv
// rtl/vx_raster_stamp_packer.sv - packs rasterizer stamps into raster bus requests; RASTER_PACKER_PERF_EN adds perf counters
module vx_raster_stamp_packer #(
    parameter int NUM_LANES     = 4,
    parameter int STAMP_W       = vx_raster_stamp_packer_pkg::STAMP_W,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stamp_valid,
    input  logic [STAMP_W-1:0]           stamp_data,
    output logic                         stamp_ready,
    input  logic                         raster_idle,
    input  logic                         frame_start,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [NUM_LANES*STAMP_W-1:0] req_stamps,
    output logic [NUM_LANES-1:0]         req_lane_mask,
    output logic                         req_done
`ifdef RASTER_PACKER_PERF_EN
    ,
    output logic [31:0]                  perf_packs,
    output logic [31:0]                  perf_partials,
    output logic [31:0]                  perf_stalls
`endif
);

    import vx_raster_stamp_packer_pkg::*;

    localparam int CNT_W = $clog2(NUM_LANES + 1);
    localparam int TMR_W = $clog2(FLUSH_TIMEOUT + 1);

    pack_state_t                  state;
    logic [CNT_W-1:0]             count;
    logic [NUM_LANES*STAMP_W-1:0] buf_lanes;
    logic [NUM_LANES-1:0]         buf_mask;
    logic                         out_valid;
    logic [NUM_LANES*STAMP_W-1:0] out_stamps;
    logic [NUM_LANES-1:0]         out_mask;
    logic [TMR_W-1:0]             idle_cnt;

    logic run;
    logic buf_full;
    logic accept;
    logic timeout_hit;
    logic flush_cond;
    logic transfer;
    logic consume;

    assign run         = (state == ST_RUN);
    assign buf_full    = (count == CNT_W'(NUM_LANES));
    assign stamp_ready = run && !buf_full;
    assign accept      = stamp_valid && stamp_ready;
    assign timeout_hit = (count != '0) && (idle_cnt == TMR_W'(FLUSH_TIMEOUT - 1));
    assign flush_cond  = buf_full || timeout_hit || (raster_idle && (count != '0));
    assign transfer    = run && flush_cond && (!out_valid || req_ready);
    assign consume     = run && out_valid && req_ready;

    vx_raster_pack_buf #(
        .NUM_LANES (NUM_LANES),
        .STAMP_W   (STAMP_W),
        .CNT_W     (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (reset),
        .push      (accept),
        .push_data (stamp_data),
        .pop       (transfer),
        .count     (count),
        .lanes     (buf_lanes),
        .lane_mask (buf_mask)
    );

    // Counter saturates at the timeout value so a blocked flush fires on the first free cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (accept || transfer) begin
            idle_cnt <= '0;
        end else if ((count != '0) && !buf_full && !timeout_hit) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_stamps <= '0;
            out_mask   <= '0;
        end else if (transfer) begin
            out_valid  <= 1'b1;
            out_stamps <= buf_lanes;
            out_mask   <= buf_mask;
        end else if (consume) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (raster_idle && (count == '0) && !out_valid && !stamp_valid) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (frame_start) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // DONE is a sticky request with empty payload that every warp observes.
    assign req_valid     = run ? out_valid : 1'b1;
    assign req_done      = !run;
    assign req_lane_mask = (run && out_valid) ? out_mask : '0;
    assign req_stamps    = (run && out_valid) ? out_stamps : '0;

`ifdef RASTER_PACKER_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_packs    <= '0;
            perf_partials <= '0;
            perf_stalls   <= '0;
        end else begin
            if (transfer && buf_full) begin
                perf_packs <= perf_packs + 32'd1;
            end
            if (transfer && !buf_full) begin
                perf_partials <= perf_partials + 32'd1;
            end
            if (run && out_valid && !req_ready) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
